hl_half_reader: RTL and testbench
=================================

# hl_half_reader

Read-side companion to the team's split high/low load register: accepts full N-bit words over a valid/ready handshake and streams them out as N/2-bit halves, high half first, over a narrow valid/ready port. A per-word 2-bit select (same meaning as loadh/loadl on the write side) chooses which halves are emitted. Sits between a wide datapath word source and an N/2-bit bus or byte-wide sink.

## Interface
- N, default 16, word width; must be even and ≥ 4
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- in_valid  input  1  word offered
- in_ready  output  1  block can accept a word this cycle
- in_data  input  N  word to read out
- in_sel  input  2  {hi, lo} halves to emit; 2'b00 = consume and discard
- out_valid  output  1  half available
- out_ready  input  1  sink takes the half this cycle
- out_data  output  N/2  half payload
- out_hi  output  1  1 = out_data is the high half
- out_last  output  1  final half of the current word
- busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, SEND_H, SEND_L.
- Input handshake when in_valid && in_ready; word and in_sel captured into the internal buffer.
- Next state on capture: sel 1x → SEND_H; sel 01 → SEND_L; sel 00 → IDLE (word dropped, no output beat).
- SEND_H: out_data = word[N-1:N/2], out_hi = 1, out_last = ~sel[0]. On output handshake: sel[0] → SEND_L, else end-of-word.
- SEND_L: out_data = word[N/2-1:0], out_hi = 0, out_last = 1. On output handshake: end-of-word.
- End-of-word: if a word is captured in the same cycle, go straight to its first state (back-to-back); else IDLE.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). Combinational from state and out_ready only; never from in_valid.
- out_valid = (state == SEND_H || state == SEND_L).
- While out_valid && !out_ready, out_data/out_hi/out_last hold stable.
- in_data/in_sel are ignored when no input handshake occurs.

## Timing
- Reset (clear_n low, asynchronous): state IDLE, buffer 0; out_valid 0, out_data 0, out_hi 0, out_last 0, busy 0; in_ready 1 once reset is released.
- Latency: input handshake at edge t → first half valid in the cycle after t.
- Throughput: sel 11 sustains one half per cycle, one word per 2 cycles with no bubble; sel 10/01 one word per cycle.
- sel 00: in_ready stays 1; consecutive discarded words accepted every cycle.
- Reset asserted mid-word: partial word dropped, no further beats; out_valid falls asynchronously.

## Configuration
- HL_PARITY_EN defined: extra output out_par (1 bit) = even parity (XOR reduction) of out_data, valid with out_valid, reset 0.
- Not defined: port out_par absent; no other behaviour change.

## Structure
- Package hl_pkg: state enum typedef (IDLE, SEND_H, SEND_L), localparams SEL_NONE=2'b00, SEL_LO=2'b01, SEL_HI=2'b10, SEL_BOTH=2'b11.
- One natural sub-module: hl_word_buf — N-bit word plus 2-bit select holding register with async active-low clear and load enable; the FSM and output mux live in hl_half_reader.

## Test plan
- Reset then word 16'hA55A, sel 11, out_ready=1 → beats 8'hA5 (hi=1, last=0), 8'h5A (hi=0, last=1) on consecutive cycles; in_ready high again on the second beat.
- 16'h1234 sel 10, then 16'h5678 sel 01, back-to-back → 8'h12 (hi, last), then 8'h78 (lo, last); no idle cycle between.
- 16'hBEEF sel 11, out_ready low 3 cycles on first beat → 8'hBE held stable 4 cycles, in_ready low; then 8'hEF.
- Three words with sel 00 on consecutive cycles → all accepted, in_ready constantly 1, out_valid never asserted.
- clear_n pulsed low during SEND_L of 16'hCAFE → out_valid drops immediately, 8'hFE never transferred; next word 16'h0102 sel 11 emits 8'h01, 8'h02.
- HL_PARITY_EN: 16'h0703 sel 11 → out_par 1 on 8'h07, 0 on 8'h03.

Source files
------------

// File: rtl/hl_pkg.sv
// rtl/hl_pkg.sv - shared state encoding and select codes for the half reader
package hl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_H = 2'd1,
    SEND_L = 2'd2
  } hl_state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  // First state for a freshly captured word; the high half always goes first.
  function automatic hl_state_e first_state(input logic [1:0] sel);
    hl_state_e st;
    case (sel)
      SEL_BOTH, SEL_HI: st = SEND_H;
      SEL_LO:           st = SEND_L;
      default:          st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/hl_word_buf.sv
// rtl/hl_word_buf.sv - word and half-select holding register with load enable
module hl_word_buf #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load_i,
  input  logic [N-1:0] word_i,
  input  logic [1:0]   sel_i,
  output logic [N-1:0] word_o,
  output logic [1:0]   sel_o
);

  logic [N-1:0] word_q;
  logic [1:0]   sel_q;

  // Capture the accepted word and its select; cleared asynchronously.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      word_q <= '0;
      sel_q  <= '0;
    end else if (load_i) begin
      word_q <= word_i;
      sel_q  <= sel_i;
    end
  end

  assign word_o = word_q;
  assign sel_o  = sel_q;

endmodule

// File: rtl/hl_half_reader.sv
// rtl/hl_half_reader.sv - streams N-bit words as N/2-bit halves, high first (HL_PARITY_EN adds out_par)
module hl_half_reader
  import hl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           clear_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [1:0]     in_sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N/2-1:0] out_data,
  output logic           out_hi,
  output logic           out_last,
  output logic           busy
`ifdef HL_PARITY_EN
  ,
  output logic           out_par
`endif
);

  localparam int H = N / 2;

  hl_state_e    state_q, state_d;
  logic [N-1:0] word_q;
  logic [1:0]   sel_q;
  logic         capture;

  hl_word_buf #(.N(N)) u_buf (
    .clk     (clk),
    .clear_n (clear_n),
    .load_i  (capture),
    .word_i  (in_data),
    .sel_i   (in_sel),
    .word_o  (word_q),
    .sel_o   (sel_q)
  );

  // State register; reset drops any partially sent word.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output mux, ready generation and next-state; outputs read 0 when no beat is offered.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_hi    = 1'b0;
    out_last  = 1'b0;

    case (state_q)
      SEND_H: begin
        out_valid = 1'b1;
        out_data  = word_q[N-1:H];
        out_hi    = 1'b1;
        out_last  = ~sel_q[0];
      end
      SEND_L: begin
        out_valid = 1'b1;
        out_data  = word_q[H-1:0];
        out_last  = 1'b1;
      end
      default: ;
    endcase

    in_ready = (state_q == IDLE) || (out_valid && out_ready && out_last);
    capture  = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (capture) state_d = first_state(in_sel);
      end
      SEND_H: begin
        if (out_ready) begin
          if (sel_q[0])     state_d = SEND_L;
          else if (capture) state_d = first_state(in_sel);
          else              state_d = IDLE;
        end
      end
      SEND_L: begin
        if (out_ready) begin
          if (capture) state_d = first_state(in_sel);
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef HL_PARITY_EN
  assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_hl_half_reader.sv
// tb/tb_hl_half_reader.sv - scoreboard bench for hl_half_reader (HL_PARITY_EN optional)
module tb_hl_half_reader;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_hi;
  logic        out_last;
  logic        busy;
`ifdef HL_PARITY_EN
  logic        out_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  hl_half_reader #(.N(16)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hi    (out_hi),
    .out_last  (out_last),
    .busy      (busy)
`ifdef HL_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic hi, input logic last);
    exp_q.push_back({d, hi, last});
  endtask

  // Offer one word and hold it until the handshake edge passes.
  task automatic put(input logic [15:0] w, input logic [1:0] s);
    int n;
    in_data  = w;
    in_sel   = s;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("put_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pops expected beats on every output handshake, checks hold during stalls.
  logic       stall_v = 1'b0;
  logic [9:0] stall_val = '0;
  always @(negedge clk) begin
    logic [9:0] e;
    if (stall_v && out_valid)
      chk("stall_hold", {22'd0, out_data, out_hi, out_last}, {22'd0, stall_val});
    stall_v   = out_valid && !out_ready;
    stall_val = {out_data, out_hi, out_last};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {22'd0, out_data, out_hi, out_last}, 32'h3ff);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", {24'd0, out_data}, {24'd0, e[9:2]});
        chk("beat_hi",   {31'd0, out_hi},   {31'd0, e[1]});
        chk("beat_last", {31'd0, out_last}, {31'd0, e[0]});
`ifdef HL_PARITY_EN
        chk("beat_par",  {31'd0, out_par},  {31'd0, ^e[9:2]});
`endif
      end
    end
  end

  initial begin
    int n;
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_hi",    {31'd0, out_hi},    32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // A55A sel 11: hi then lo on consecutive cycles
    expect_beat(8'hA5, 1'b1, 1'b0);
    expect_beat(8'h5A, 1'b0, 1'b1);
    put(16'hA55A, 2'b11);
    @(negedge clk);
    chk("t1_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_in_ready_hi",   {31'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_second_valid",  {31'd0, out_valid}, 32'd1);
    chk("t1_in_ready_lo",   {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;

    // 1234 sel 10 then 5678 sel 01, back-to-back
    expect_beat(8'h12, 1'b1, 1'b1);
    expect_beat(8'h78, 1'b0, 1'b1);
    put(16'h1234, 2'b10);
    put(16'h5678, 2'b01);
    @(negedge clk);
    chk("t2_no_bubble", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_idle_after", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // BEEF sel 11 with a 3-cycle stall on the high beat
    expect_beat(8'hBE, 1'b1, 1'b0);
    expect_beat(8'hEF, 1'b0, 1'b1);
    out_ready = 1'b0;
    put(16'hBEEF, 2'b11);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      @(negedge clk);
      chk("t3_hold_data", {24'd0, out_data}, 32'h0000_00BE);
      chk("t3_in_ready",  {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t3_low_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Three discarded words on consecutive cycles
    for (int i = 0; i < 3; i++) begin
      put(16'h1111 * (i + 1), 2'b00);
      chk("t4_no_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready},  32'd1);
    end

    // CAFE sel 11, reset during SEND_L
    expect_beat(8'hCA, 1'b1, 1'b0);
    put(16'hCAFE, 2'b11);
    @(negedge clk);
    @(posedge clk); #1;
    chk("t5_in_send_l", {31'd0, out_valid}, 32'd1);
    clear_n = 1'b0;
    #1;
    chk("t5_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t5_busy_drop",  {31'd0, busy},      32'd0);
    chk("t5_data_zero",  {24'd0, out_data},  32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready_after", {31'd0, in_ready}, 32'd1);
    expect_beat(8'h01, 1'b1, 1'b0);
    expect_beat(8'h02, 1'b0, 1'b1);
    put(16'h0102, 2'b11);

`ifdef HL_PARITY_EN
    expect_beat(8'h07, 1'b1, 1'b0);
    expect_beat(8'h03, 1'b0, 1'b1);
    put(16'h0703, 2'b11);
    @(negedge clk);
    chk("par_hi", {31'd0, out_par}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("par_lo", {31'd0, out_par}, 32'd0);
`endif

    // Drain remaining expectations
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("final_idle",  {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
